// File: rtl/mipi_rx_lane_aligner_n.sv
// Lane deskew for a MIPI CSI-2/DSI receiver: waits for every lane's byte aligner to start,
// measures the arrival spread, then taps a per-lane delay line so all lanes emit their bytes together.
module mipi_rx_lane_aligner_n #(
   parameter int MIPI_LANES = 4,
   parameter int MAX_SKEW   = 3
) (
   input  logic                    clk_i,
   input  logic                    reset_in,
   input  logic [MIPI_LANES-1:0]   bytes_valid_i,
   input  logic [8*MIPI_LANES-1:0] byte_i,
   output logic                    lane_valid_o,
   output logic [8*MIPI_LANES-1:0] lane_byte_o,
   output logic                    align_err_o,
   output logic [2:0]              skew_o
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WAIT_ALL = 3'd1;
   localparam logic [2:0] ST_ALIGNED  = 3'd2;
   localparam logic [2:0] ST_DRAIN    = 3'd3;
   localparam logic [2:0] ST_ERROR    = 3'd4;

   localparam logic [2:0] SKEW_LIMIT  = 3'(MAX_SKEW);
   localparam bit         SINGLE_LANE = (MIPI_LANES == 1);

   logic [2:0]                          state_q, state_d;
   logic [2:0]                          cnt_q, cnt_d;
   logic [MIPI_LANES-1:0]               arrived_q, arrived_d;
   logic [MIPI_LANES-1:0][2:0]          offset_q, offset_d;
   logic [MIPI_LANES-1:0][2:0]          tap_q, tap_d;
   logic [MIPI_LANES-1:0][MAX_SKEW-1:0][8:0] dl_q;
   logic                                lane_valid_q, lane_valid_d;
   logic [8*MIPI_LANES-1:0]             lane_byte_q, lane_byte_d;
   logic                                align_err_q, align_err_d;
   logic [2:0]                          skew_q, skew_d;

   logic [MIPI_LANES-1:0][MAX_SKEW:0][8:0] stage;
   logic [MIPI_LANES-1:0][2:0]          tap_use;
   logic [MIPI_LANES-1:0]               tap_valid;
   logic [8*MIPI_LANES-1:0]             tap_byte;
   logic [2:0]                          cnt_now;
   logic [MIPI_LANES-1:0]               arrived_now;
   logic                                all_arrived;
   logic                                any_valid;
   logic                                all_valid;

   assign any_valid = |bytes_valid_i;
   assign all_valid = &bytes_valid_i;

   // Stage 0 is the live input, so a tap of 0 gives the one-cycle registered passthrough.
   always_comb begin
      for (int k = 0; k < MIPI_LANES; k++) begin
         stage[k][0] = {bytes_valid_i[k], byte_i[8*k +: 8]};
         for (int j = 0; j < MAX_SKEW; j++) begin
            stage[k][j+1] = dl_q[k][j];
         end
      end
   end

   // Taps in force this cycle: zero from IDLE, freshly computed on the cycle the last lane arrives.
   always_comb begin
      cnt_now     = cnt_q + 3'd1;
      arrived_now = arrived_q | bytes_valid_i;
      all_arrived = &arrived_now;
      tap_use     = tap_q;
      if (state_q == ST_IDLE) begin
         tap_use = '0;
      end else if (state_q == ST_WAIT_ALL && all_arrived) begin
         for (int k = 0; k < MIPI_LANES; k++) begin
            tap_use[k] = arrived_q[k] ? (cnt_now - offset_q[k]) : 3'd0;
         end
      end
   end

   always_comb begin
      tap_valid = '0;
      tap_byte  = '0;
      for (int k = 0; k < MIPI_LANES; k++) begin
         for (int j = 0; j <= MAX_SKEW; j++) begin
            if (tap_use[k] == 3'(j)) begin
               tap_valid[k]        = stage[k][j][8];
               tap_byte[8*k +: 8]  = stage[k][j][7:0];
            end
         end
      end
   end

   always_comb begin
      // NOTE: every *_d gets its hold value first, so no branch leaves one unassigned and no latch is inferred.
      state_d      = state_q;
      cnt_d        = cnt_q;
      arrived_d    = arrived_q;
      offset_d     = offset_q;
      tap_d        = tap_q;
      lane_valid_d = 1'b0;
      lane_byte_d  = lane_byte_q;
      align_err_d  = 1'b0;
      skew_d       = skew_q;

      case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               cnt_d     = 3'd0;
               arrived_d = bytes_valid_i;
               offset_d  = '0;
               if (all_valid) begin
                  tap_d        = '0;
                  skew_d       = 3'd0;
                  lane_valid_d = &tap_valid;
                  lane_byte_d  = tap_byte;
                  state_d      = ST_ALIGNED;
               end else begin
                  state_d = ST_WAIT_ALL;
               end
            end
         end

         ST_WAIT_ALL: begin
            cnt_d     = cnt_now;
            arrived_d = arrived_now;
            for (int k = 0; k < MIPI_LANES; k++) begin
               if (!arrived_q[k] && bytes_valid_i[k]) begin
                  offset_d[k] = cnt_now;
               end
            end
            if (all_arrived) begin
               tap_d        = tap_use;
               skew_d       = cnt_now;
               lane_valid_d = &tap_valid;
               lane_byte_d  = tap_byte;
               state_d      = ST_ALIGNED;
            end else if (cnt_now >= SKEW_LIMIT) begin
               // Another cycle would push the spread past MAX_SKEW with a lane still missing.
               align_err_d = 1'b1;
               state_d     = ST_ERROR;
            end
         end

         ST_ALIGNED: begin
            if (&tap_valid) begin
               lane_valid_d = 1'b1;
               lane_byte_d  = tap_byte;
            end else begin
               // A lone lane has nothing to drain, and skipping DRAIN keeps it a true passthrough.
               state_d = SINGLE_LANE ? ST_IDLE : ST_DRAIN;
            end
         end

         ST_DRAIN, ST_ERROR: begin
            if (!any_valid) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use <= so each one samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge reset_in) begin
      if (!reset_in) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 3'd0;
         arrived_q    <= '0;
         offset_q     <= '0;
         tap_q        <= '0;
         lane_valid_q <= 1'b0;
         lane_byte_q  <= '0;
         align_err_q  <= 1'b0;
         skew_q       <= 3'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         arrived_q    <= arrived_d;
         offset_q     <= offset_d;
         tap_q        <= tap_d;
         lane_valid_q <= lane_valid_d;
         lane_byte_q  <= lane_byte_d;
         align_err_q  <= align_err_d;
         skew_q       <= skew_d;
      end
   end

   // NOTE: the delay lines are reset as well, so a tap into a stage not yet refilled after reset
   // reads an invalid entry instead of a stale byte from the aborted burst.
   always_ff @(posedge clk_i or negedge reset_in) begin
      if (!reset_in) begin
         dl_q <= '0;
      end else begin
         for (int k = 0; k < MIPI_LANES; k++) begin
            dl_q[k][0] <= {bytes_valid_i[k], byte_i[8*k +: 8]};
            for (int j = 1; j < MAX_SKEW; j++) begin
               dl_q[k][j] <= dl_q[k][j-1];
            end
         end
      end
   end

   assign lane_valid_o = lane_valid_q;
   assign lane_byte_o  = lane_byte_q;
   assign align_err_o  = align_err_q;
   assign skew_o       = skew_q;

endmodule

// File: tb/tb_mipi_rx_lane_aligner_n.sv
// Directed bench for mipi_rx_lane_aligner_n: 4-lane/skew-3 main instance plus 8-lane/skew-7 and
// single-lane instances, all checked against hand-computed words.
module tb_mipi_rx_lane_aligner_n;

   logic clk_i    = 1'b0;
   logic reset_in = 1'b0;

   logic [3:0]  v4 = '0;
   logic [31:0] b4 = '0;
   logic        lv4;
   logic [31:0] lb4;
   logic        err4;
   logic [2:0]  sk4;

   logic [7:0]  v8 = '0;
   logic [63:0] b8 = '0;
   logic        lv8;
   logic [63:0] lb8;
   logic        err8;
   logic [2:0]  sk8;

   logic [0:0]  v1 = '0;
   logic [7:0]  b1 = '0;
   logic        lv1;
   logic [7:0]  lb1;
   logic        err1;
   logic [2:0]  sk1;

   int checks   = 0;
   int failures = 0;

   bit         pat_v [8];
   logic [7:0] pat_b [8];
   logic [31:0] exp_w;

   always #5 clk_i = ~clk_i;

   mipi_rx_lane_aligner_n #(.MIPI_LANES(4), .MAX_SKEW(3)) dut (
      .clk_i(clk_i), .reset_in(reset_in), .bytes_valid_i(v4), .byte_i(b4),
      .lane_valid_o(lv4), .lane_byte_o(lb4), .align_err_o(err4), .skew_o(sk4)
   );

   mipi_rx_lane_aligner_n #(.MIPI_LANES(8), .MAX_SKEW(7)) dut8 (
      .clk_i(clk_i), .reset_in(reset_in), .bytes_valid_i(v8), .byte_i(b8),
      .lane_valid_o(lv8), .lane_byte_o(lb8), .align_err_o(err8), .skew_o(sk8)
   );

   mipi_rx_lane_aligner_n #(.MIPI_LANES(1), .MAX_SKEW(3)) dut1 (
      .clk_i(clk_i), .reset_in(reset_in), .bytes_valid_i(v1), .byte_i(b1),
      .lane_valid_o(lv1), .lane_byte_o(lb1), .align_err_o(err1), .skew_o(sk1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // One byte-clock cycle; outputs are sampled 1 ns after the edge.
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      // Reset with live traffic on the inputs: outputs must still read zero.
      v4 = 4'hF; b4 = 32'hDEADBEEF;
      repeat (3) cyc();
      check("rst_valid", 64'(lv4), 64'(0));
      check("rst_byte", 64'(lb4), 64'(0));
      check("rst_err", 64'(err4), 64'(0));
      check("rst_skew", 64'(sk4), 64'(0));
      check("rst_valid8", 64'(lv8), 64'(0));
      check("rst_valid1", 64'(lv1), 64'(0));
      v4 = 4'h0; b4 = '0;
      reset_in = 1'b1;
      repeat (2) cyc();
      check("idle_valid", 64'(lv4), 64'(0));

      // All lanes arrive together.
      v4 = 4'hF; b4 = 32'h44332211;
      cyc();
      check("t28_valid", 64'(lv4), 64'(1));
      check("t28_byte", 64'(lb4), 64'(32'h44332211));
      check("t28_skew", 64'(sk4), 64'(0));
      b4 = 32'hA1B2C3D4;
      cyc();
      check("t28_word1", 64'(lb4), 64'(32'hA1B2C3D4));
      v4 = 4'h0; b4 = '0;
      cyc();
      check("t28_end_valid", 64'(lv4), 64'(0));
      cyc();

      // Lane k rises at c=k, first byte 0xB8, then {k, index}; six bytes per lane.
      for (int c = 0; c < 11; c++) begin
         for (int k = 0; k < 4; k++) begin
            v4[k] = (c >= k) && (c < k + 6);
            b4[8*k +: 8] = (c == k) ? 8'hB8 : (v4[k] ? {4'(k), 4'(c - k)} : 8'h00);
         end
         cyc();
         if (c < 3) check("t29_wait_valid", 64'(lv4), 64'(0));
         if (c == 2) check("t29_skew_before", 64'(sk4), 64'(0));
         if (c == 3) begin
            check("t29_first_valid", 64'(lv4), 64'(1));
            check("t29_first_word", 64'(lb4), 64'(32'hB8B8B8B8));
            check("t29_skew", 64'(sk4), 64'(3));
         end
         if (c == 4) check("t29_word1", 64'(lb4), 64'(32'h31211101));
         if (c == 5) check("t29_word2", 64'(lb4), 64'(32'h32221202));
         if (c == 8) check("t29_last_valid", 64'(lv4), 64'(1));
         if (c == 9) check("t29_end_valid", 64'(lv4), 64'(0));
      end

      // Lanes 0..2 rise at c=0..2, lane 3 at c=4: spread of 4 exceeds MAX_SKEW.
      for (int c = 0; c < 9; c++) begin
         for (int k = 0; k < 4; k++) begin
            v4[k] = (c >= ((k == 3) ? 4 : k)) && (c < 7);
            b4[8*k +: 8] = v4[k] ? 8'(8'h60 + k) : 8'h00;
         end
         cyc();
         check("t30_no_valid", 64'(lv4), 64'(0));
         if (c == 3) check("t30_err_pulse", 64'(err4), 64'(1));
         else        check("t30_err_low", 64'(err4), 64'(0));
         check("t30_skew_held", 64'(sk4), 64'(3));
      end
      v4 = 4'hF; b4 = 32'h0A0B0C0D;
      cyc();
      check("t30_idle_again_valid", 64'(lv4), 64'(1));
      check("t30_idle_again_byte", 64'(lb4), 64'(32'h0A0B0C0D));
      check("t30_idle_again_skew", 64'(sk4), 64'(0));
      v4 = 4'h0; b4 = '0;
      cyc();
      cyc();

      // 100-word aligned burst; lane 2 stops at word 60.
      for (int w = 0; w < 100; w++) begin
         for (int k = 0; k < 4; k++) begin
            v4[k] = !(k == 2 && w >= 60);
            b4[8*k +: 8] = 8'(w) + 8'(k * 64);
            exp_w[8*k +: 8] = 8'(w) + 8'(k * 64);
         end
         cyc();
         if (w < 60) begin
            check("t31_valid", 64'(lv4), 64'(1));
            check("t31_byte", 64'(lb4), 64'(exp_w));
         end else begin
            check("t31_drained", 64'(lv4), 64'(0));
         end
      end
      v4 = 4'h0; b4 = '0;
      cyc();
      check("t31_after_valid", 64'(lv4), 64'(0));

      // Reset lands at word 5 of an aligned burst.
      for (int w = 0; w < 5; w++) begin
         v4 = 4'hF; b4 = 32'h90A0B0C0 + 32'h01010101 * 32'(w);
         cyc();
         check("t32_pre_byte", 64'(lb4), 64'(32'h90A0B0C0 + 32'h01010101 * 32'(w)));
      end
      b4 = 32'h95A5B5C5;
      reset_in = 1'b0;
      #1;
      check("t32_rst_valid", 64'(lv4), 64'(0));
      check("t32_rst_byte", 64'(lb4), 64'(0));
      check("t32_rst_err", 64'(err4), 64'(0));
      check("t32_rst_skew", 64'(sk4), 64'(0));
      cyc();
      cyc();
      check("t32_held_valid", 64'(lv4), 64'(0));
      b4 = 32'h55667788;
      reset_in = 1'b1;
      cyc();
      check("t32_rearrive_valid", 64'(lv4), 64'(1));
      check("t32_rearrive_byte", 64'(lb4), 64'(32'h55667788));
      v4 = 4'h0; b4 = '0;
      cyc();
      cyc();
      // Lanes 0,1 at c=0, lane 2 at c=1, lane 3 at c=2.
      for (int c = 0; c < 6; c++) begin
         for (int k = 0; k < 4; k++) begin
            v4[k] = c >= ((k < 2) ? 0 : k - 1);
            b4[8*k +: 8] = v4[k] ? 8'(8'hC0 + 16 * (c - ((k < 2) ? 0 : k - 1)) + k) : 8'h00;
         end
         cyc();
         if (c < 2) check("t32_wait_valid", 64'(lv4), 64'(0));
         if (c == 2) begin
            check("t32_valid", 64'(lv4), 64'(1));
            check("t32_word0", 64'(lb4), 64'(32'hC3C2C1C0));
            check("t32_skew", 64'(sk4), 64'(2));
         end
         if (c == 3) check("t32_word1", 64'(lb4), 64'(32'hD3D2D1D0));
      end
      v4 = 4'h0; b4 = '0;
      cyc();
      cyc();

      // Eight lanes, lane k rises at c=k: the full 7-cycle spread is still legal.
      for (int c = 0; c < 9; c++) begin
         for (int k = 0; k < 8; k++) begin
            v8[k] = c >= k;
            b8[8*k +: 8] = v8[k] ? 8'(16 * (c - k) + k) : 8'h00;
         end
         cyc();
         if (c < 7) check("t33_wait8", 64'(lv8), 64'(0));
         if (c == 6) check("t33_no_err8", 64'(err8), 64'(0));
         if (c == 7) begin
            check("t33_valid8", 64'(lv8), 64'(1));
            check("t33_word8", 64'(lb8), 64'h0706050403020100);
            check("t33_skew8", 64'(sk8), 64'(7));
            check("t33_err8", 64'(err8), 64'(0));
         end
         if (c == 8) check("t33_word8_1", 64'(lb8), 64'h1716151413121110);
      end
      v8 = '0; b8 = '0;
      cyc();

      // Single lane: registered passthrough, including one-cycle gaps.
      pat_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      pat_b = '{8'h5A, 8'h5B, 8'h00, 8'h5C, 8'h00, 8'h00, 8'h5D, 8'h00};
      for (int c = 0; c < 8; c++) begin
         v1 = pat_v[c];
         b1 = pat_b[c];
         cyc();
         check("t33_valid1", 64'(lv1), 64'(pat_v[c]));
         if (pat_v[c]) check("t33_byte1", 64'(lb1), 64'(pat_b[c]));
         check("t33_skew1", 64'(sk1), 64'(0));
         check("t33_err1", 64'(err1), 64'(0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mipi_rx_lane_aligner_n.md
MIPI_RX_LANE_ALIGNER_N -- requirements
Module: mipi_rx_lane_aligner_n

Interface
REQ-001 SHALL have parameter MIPI_LANES, default 4, number of data lanes; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter MAX_SKEW, default 3, maximum inter-lane arrival skew in byte-clock cycles; legal values 1..7.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk_i  input  1  byte clock; all logic on its rising edge.
REQ-005 reset_in  input  1  asynchronous active-low reset.
REQ-006 bytes_valid_i  input  MIPI_LANES  per-lane byte-aligner valid; lane k is bit k.
REQ-007 byte_i  input  8*MIPI_LANES  per-lane aligned byte; lane k is bits [8k+7:8k].
REQ-008 lane_valid_o  output  1  deskewed word valid.
REQ-009 lane_byte_o  output  8*MIPI_LANES  deskewed word; lane order as byte_i.
REQ-010 align_err_o  output  1  one-cycle pulse on skew-timeout failure.
REQ-011 skew_o  output  3  measured skew (last arrival minus first arrival) of the current or last burst.

Function
REQ-012 SHALL hold, per lane, a delay line of MAX_SKEW+1 stages of {valid, byte}, shifted every cycle.
REQ-013 SHALL implement states IDLE, WAIT_ALL, ALIGNED, DRAIN, ERROR.
REQ-014 IDLE: on the first cycle any bytes_valid_i bit is 1, SHALL clear the arrival counter to 0, mark the lanes valid that cycle as arrived with offset 0, and go to WAIT_ALL; if all lanes are valid that same cycle, SHALL go directly to ALIGNED with all taps 0.
REQ-015 WAIT_ALL: SHALL increment the arrival counter each cycle and record, for each lane whose valid first rises, offset = counter value.
REQ-016 WAIT_ALL: when all lanes have arrived with counter <= MAX_SKEW, SHALL set tap[k] = (final counter - offset[k]), set skew_o = final counter, and go to ALIGNED.
REQ-017 WAIT_ALL: if the counter would exceed MAX_SKEW with any lane not arrived, SHALL pulse align_err_o for one cycle, hold skew_o unchanged, and go to ERROR.
REQ-018 ALIGNED: lane_byte_o lane k SHALL be the delay-line stage tap[k] of lane k, registered; lane_valid_o SHALL be 1 while every lane's tapped valid is 1.
REQ-019 Latency: the first lane_valid_o SHALL assert exactly 1 cycle after the cycle in which the last lane's valid first rises; that word SHALL contain each lane's first byte.
REQ-020 ALIGNED: on the first cycle any tapped valid is 0, SHALL deassert lane_valid_o (next cycle) and go to DRAIN.
REQ-021 DRAIN and ERROR: lane_valid_o SHALL be 0; SHALL return to IDLE on the first cycle all bytes_valid_i bits are 0.
REQ-022 A lane deasserting valid and reasserting within one burst SHALL end the burst (REQ-020); no re-alignment mid-burst.
REQ-023 With MIPI_LANES = 1, SHALL pass valid and byte through with 1-cycle latency, skew_o = 0, and never assert align_err_o.
REQ-024 lane_byte_o SHALL be don't-care when lane_valid_o = 0, but SHALL NOT change when lane_valid_o is 0 in IDLE.

Reset
REQ-025 reset_in low SHALL immediately force: state IDLE, lane_valid_o 0, lane_byte_o 0, align_err_o 0, skew_o 0, all taps, offsets, counter, and delay lines 0.
REQ-026 Reset asserted mid-burst SHALL abort with no further lane_valid_o; after release, lanes already valid SHALL be treated as new arrivals per REQ-014.
REQ-027 Release of reset_in is synchronised externally; no output SHALL change in the release cycle other than per REQ-014.

Verification
REQ-028 LANES=4, all valid rise at cycle 10, bytes 0x11/0x22/0x33/0x44 -> lane_valid_o at 11, lane_byte_o = 0x44332211, skew_o = 0.
REQ-029 Lanes 0,1,2,3 rise at cycles 10,11,12,13 (each first byte 0xB8) -> lane_valid_o at 14, first word 0xB8B8B8B8, skew_o = 3, taps 3,2,1,0.
REQ-030 Lane 3 rises at cycle 14 (skew 4 > MAX_SKEW=3) -> align_err_o pulse at 14, no lane_valid_o; IDLE once all valid low.
REQ-031 Aligned burst of 100 words, lane 2 drops valid early at word 60 -> lane_valid_o drops after word 59, DRAIN, IDLE after all low.
REQ-032 reset_in low at word 5 of an aligned burst -> all outputs 0 immediately; next burst after release aligns with correct skew_o.
REQ-033 MIPI_LANES=8, MAX_SKEW=7, lane k rises at cycle 10+k -> lane_valid_o at 18, skew_o = 7; MIPI_LANES=1 -> 1-cycle passthrough.
